// File: rtl/usart_tx_feeder_pkg.sv
// Shared constants and FSM encoding for the USART transmit feeder.
package usart_tx_feeder_pkg;

  localparam int unsigned ByteW          = 8;
  localparam int unsigned DefaultBaudDiv = 1250;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StStart    = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } tx_state_e;

endpackage

// File: rtl/usart_tx_feeder_if.sv
// Core-side write port, UART handshake and status of the transmit feeder.
interface usart_tx_feeder_if #(
  parameter int unsigned ADDR_W = 4
) ();
  import usart_tx_feeder_pkg::*;

  logic             wr_en;
  logic [ByteW-1:0] wr_data;
  logic             full;
  logic             empty;
  logic [ADDR_W:0]  level;
  logic [ByteW-1:0] tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic             overflow;
  logic             timeout_err;
  logic             clear_flags;

  modport master (
    output wr_en, wr_data, tx_busy, clear_flags,
    input  full, empty, level, tx_data, tx_start, overflow, timeout_err
  );

  modport slave (
    input  wr_en, wr_data, tx_busy, clear_flags,
    output full, empty, level, tx_data, tx_start, overflow, timeout_err
  );

endinterface

// File: rtl/usart_byte_fifo.sv
// Circular byte FIFO with registered occupancy and write-drop detection.
module usart_byte_fifo
  import usart_tx_feeder_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [ByteW-1:0] wr_data,
  input  logic             rd_en,
  output logic [ByteW-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [ADDR_W:0]  level,
  output logic             wr_drop
);

  logic [ByteW-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              push, pop;

  assign full    = (level_q == (ADDR_W+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  // A write while full is dropped even if a pop frees a slot this same cycle.
  assign push    = wr_en && !full;
  assign wr_drop = wr_en && full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (push && !pop)      level_d = level_q + (ADDR_W+1)'(1);
    else if (pop && !push) level_d = level_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/usart_tx_feeder.sv
// Buffers core bytes and hands them one at a time to the UART via start/busy.
module usart_tx_feeder
  import usart_tx_feeder_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input logic              clock,
  input logic              reset,
  usart_tx_feeder_if.slave bus
);

  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

  tx_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ByteW-1:0] tx_data_q, tx_data_d;
  logic [ByteW-1:0] fifo_rd_data;
  logic [ADDR_W:0]  fifo_level;
  logic             fifo_full, fifo_empty, wr_drop;
  logic             pop, timeout_set;
  logic             tx_start_q, overflow_q, timeout_q;

  usart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level),
    .wr_drop (wr_drop)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    pop         = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !bus.tx_busy) begin
          pop       = 1'b1;
          tx_data_d = fifo_rd_data;
          state_d   = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
          // UART never acknowledged: drop the byte and flag it.
          timeout_set = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (!bus.tx_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= (state_d == StStart);
      // Set events take priority over a coincident clear.
      overflow_q <= wr_drop     ? 1'b1 : (bus.clear_flags ? 1'b0 : overflow_q);
      timeout_q  <= timeout_set ? 1'b1 : (bus.clear_flags ? 1'b0 : timeout_q);
    end
  end

  assign bus.full        = fifo_full;
  assign bus.empty       = fifo_empty;
  assign bus.level       = fifo_level;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: doc/usart_tx_feeder.md
Name: usart_tx_feeder

Overview:
- Byte-buffering stage directly upstream of the my_usart transmitter.
- Accepts bytes from core logic through a write strobe and stores them in an internal FIFO.
- Sequences them one at a time into the UART using a start/busy handshake, so producers never have to poll the transmitter.
- Reports FIFO level and sticky overflow/timeout flags.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.
- BUSY_TIMEOUT, 64, cycles to wait for tx_busy to rise after tx_start before abandoning the byte.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- wr_en  input  1  write strobe; one byte per cycle while high
- wr_data  input  8  byte to enqueue
- full  output  1  FIFO holds DEPTH bytes
- empty  output  1  FIFO holds 0 bytes
- level  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH
- tx_data  output  8  byte presented to the UART
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data
- tx_busy  input  1  UART shifting a frame
- overflow  output  1  sticky; a write was dropped
- timeout_err  output  1  sticky; tx_busy failed to rise within BUSY_TIMEOUT
- clear_flags  input  1  synchronous clear of overflow and timeout_err

Behaviour:
- Reset (async assert, sync release), all outputs:
  - tx_data=0, tx_start=0, overflow=0, timeout_err=0, level=0.
  - empty=1, full=0.
  - Pointers=0, FSM=IDLE, timeout counter=0.
- FIFO storage:
  - Circular buffer with ADDR_W-bit rd/wr pointers; pointers wrap modulo DEPTH.
  - level is a registered counter. full=(level==DEPTH), empty=(level==0), both decoded from the registered level.
- Write path:
  - wr_en && !full: store wr_data at wr_ptr, wr_ptr+1, level+1.
  - wr_en && full: byte dropped, overflow<=1. This applies even if a pop occurs in the same cycle.
- Pop and write in the same cycle (not full): level unchanged, both pointers advance.
- FSM states:
  - IDLE:
    - If !empty && !tx_busy: tx_data<=fifo[rd_ptr], rd_ptr+1, level-1, go to START.
    - Otherwise remain in IDLE.
  - START:
    - tx_start=1 for exactly this cycle.
    - Clear timeout counter, go to WAIT_BUSY.
  - WAIT_BUSY:
    - If tx_busy: go to WAIT_DONE.
    - Else if counter==BUSY_TIMEOUT-1: timeout_err<=1, go to IDLE; the byte is discarded.
    - Else counter+1.
  - WAIT_DONE:
    - If !tx_busy: go to IDLE.
- tx_data handshake:
  - Held stable from START through the end of WAIT_DONE.
  - Changes only on a pop.
- tx_start is registered. It never asserts outside START and never asserts on two consecutive cycles.
- Latency: with the FSM in IDLE, FIFO empty and tx_busy=0, a write in cycle N gives:
  - empty=0 in N+1;
  - pop in N+1;
  - tx_start high in N+2.
- Back-to-back: the next pop occurs no earlier than the first IDLE cycle after tx_busy falls.
  - Minimum gap between tx_start pulses is 3 cycles plus the frame time.
- Flags:
  - clear_flags clears both flags next cycle.
  - If a set event coincides with clear_flags, the set wins.
- Reset mid-frame: FIFO contents and the in-flight byte are lost; tx_start is forced low immediately.

Decomposition:
- Shared package/header: FSM state encodings (IDLE, START, WAIT_BUSY, WAIT_DONE), default baud divisor constant 1250, byte width constant 8.
- One natural sub-module: usart_byte_fifo.
  - Provides storage, pointers, level, full/empty and overflow detect.
  - Instantiated once; the FSM and timeout counter stay in the top.

Test Plan:
- Reset then idle: assert reset mid-run → all outputs at reset values; empty=1, level=0, tx_start never pulses with FIFO empty.
- Single byte: write 0x43 at cycle N, tx_busy driven high 2 cycles after tx_start for 20 cycles → tx_start at N+2, tx_data=0x43 stable until busy falls, level returns to 0.
- Burst fill: write 0x00..0x0F back-to-back with tx_busy held high → full=1, level=16, overflow=0. A 17th write of 0xAA → overflow=1, level stays 16. Releasing busy drains 0x00..0x0F in order with no 0xAA.
- Simultaneous write and pop: level=3, write on the same cycle IDLE pops → level stays 3, data order preserved across pointer wrap (write 20 bytes total).
- Timeout: write 0x55 with tx_busy held low forever → tx_start once, timeout_err=1 exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry, FSM back in IDLE. clear_flags → timeout_err=0 next cycle.
- Reset mid-frame: reset asserted during WAIT_DONE with 5 bytes queued → level=0, tx_start=0; after release no transmission until a new write.
